// File: rtl/imgproc_pkg.sv
// Shared definitions for the image-processor message reader.
// Holds the reader FSM state type, the slave register word addresses,
// the default header/block identifiers and the flush bit position.
package imgproc_pkg;

  typedef enum logic [3:0] {
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_FAULT,
    ST_FLUSH,
    ST_POLL_WAIT,
    ST_STAT_REQ,
    ST_STAT_WAIT,
    ST_GAP,
    ST_MSG_REQ,
    ST_MSG_WAIT
  } state_e;

  localparam logic [2:0]  REG_STATUS   = 3'd0;
  localparam logic [2:0]  REG_READ_MSG = 3'd1;
  localparam logic [2:0]  REG_READ_ID  = 3'd2;

  localparam logic [31:0] MSG_ID   = 32'h0052_4242;  // "RBB"
  localparam logic [31:0] BLOCK_ID = 32'h1234_EEE2;

  localparam int          FLUSH_BIT = 4;

endpackage

// File: rtl/imgproc_msg_reader_if.sv
// Avalon-MM bus between the message reader (master) and the image
// processor's CPU register block (slave).
//   m_chipselect, m_read, m_write, m_address[2:0], m_writedata[31:0] : master -> slave
//   m_readdata[31:0] (fixed read latency 1), m_waitrequest            : slave -> master
interface imgproc_msg_reader_if;

  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    output m_chipselect, m_read, m_write, m_address, m_writedata,
    input  m_readdata, m_waitrequest
  );

  modport slave (
    input  m_chipselect, m_read, m_write, m_address, m_writedata,
    output m_readdata, m_waitrequest
  );

endinterface

// File: rtl/imgproc_msg_reader.sv
// Hardware consumer of the image processor's CPU message FIFO.
// Verifies the block ID, flushes stale messages, polls the status word and
// reads 4-word RBB messages (header, red, yellow, blue x-midpoint), then
// publishes the midpoints as registered outputs.
// Ports:
//   clk, reset_n (async, active-low), enable (1 = poll, 0 = park after message)
//   bus           : Avalon-MM master port
//   r_mid/y_mid/b_mid [10:0] : latest complete midpoints
//   mid_valid     : one-cycle pulse when the midpoints update
//   id_error      : sticky block-ID mismatch
//   hdr_err_count : discarded non-header words, saturating
//   msg_count     : completed messages, wrapping
module imgproc_msg_reader
  import imgproc_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter logic [31:0] MSG_ID        = imgproc_pkg::MSG_ID,
  parameter logic [31:0] BLOCK_ID      = imgproc_pkg::BLOCK_ID,
  parameter int unsigned MSG_WORDS     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  imgproc_msg_reader_if.master bus,
  output logic [10:0]          r_mid,
  output logic [10:0]          y_mid,
  output logic [10:0]          b_mid,
  output logic                 mid_valid,
  output logic                 id_error,
  output logic [7:0]           hdr_err_count,
  output logic [15:0]          msg_count
);

  localparam int unsigned      CNT_W       = $clog2(POLL_INTERVAL + 1);
  localparam logic [CNT_W-1:0] POLL_LOAD   = CNT_W'(POLL_INTERVAL - 1);
  localparam logic [7:0]       MSG_WORDS_B = 8'(MSG_WORDS);
  localparam logic [31:0]      FLUSH_CMD   = 32'h1 << FLUSH_BIT;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e           state_q, state_d;
  logic             cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [2:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       avail_q, avail_d;
  logic [1:0]       idx_q, idx_d;
  logic [10:0]      shr_q, shr_d, shy_q, shy_d;
  logic [10:0]      r_mid_q, r_mid_d, y_mid_q, y_mid_d, b_mid_q, b_mid_d;
  logic             mid_valid_q, mid_valid_d, id_error_q, id_error_d;
  logic [7:0]       hdr_err_q, hdr_err_d;
  logic [15:0]      msg_cnt_q, msg_cnt_d;
  logic             hunt;
  logic [31:0]      rdata;

  assign rdata = bus.m_readdata;

  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    avail_d     = avail_q;
    idx_d       = idx_q;
    shr_d       = shr_q;
    shy_d       = shy_q;
    r_mid_d     = r_mid_q;
    y_mid_d     = y_mid_q;
    b_mid_d     = b_mid_q;
    mid_valid_d = 1'b0;
    id_error_d  = id_error_q;
    hdr_err_d   = hdr_err_q;
    msg_cnt_d   = msg_cnt_q;
    hunt        = 1'b0;

    unique case (state_q)
      // Each request state spends one cycle with the bus idle before raising
      // read, which guarantees the read strobe drops between back-to-back reads
      // (the slave pops on the read rising edge).
      ST_ID_REQ, ST_STAT_REQ, ST_MSG_REQ: begin
        if (!cs_q) begin
          cs_d   = 1'b1;
          rd_d   = 1'b1;
          addr_d = (state_q == ST_ID_REQ)   ? REG_READ_ID :
                   (state_q == ST_STAT_REQ) ? REG_STATUS  : REG_READ_MSG;
        end else if (!bus.m_waitrequest) begin
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = (state_q == ST_ID_REQ)   ? ST_ID_WAIT   :
                    (state_q == ST_STAT_REQ) ? ST_STAT_WAIT : ST_MSG_WAIT;
        end
      end
      ST_ID_WAIT: begin
        if (rdata != BLOCK_ID) begin
          id_error_d = 1'b1;
          state_d    = ST_FAULT;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FAULT: begin
      end
      ST_FLUSH: begin
        if (!cs_q) begin
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = REG_STATUS;
          wdata_d = FLUSH_CMD;
        end else if (!bus.m_waitrequest) begin
          cs_d    = 1'b0;
          wr_d    = 1'b0;
          wdata_d = '0;
          cnt_d   = POLL_LOAD;
          state_d = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: begin
        // Counter freezes while disabled so the reader parks here.
        if (enable) begin
          if (cnt_q == '0) state_d = ST_STAT_REQ;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_STAT_WAIT: begin
        avail_d = rdata[15:8];
        if (idx_q == 2'd0 && rdata[15:8] < MSG_WORDS_B) begin
          cnt_d   = POLL_LOAD;
          state_d = ST_POLL_WAIT;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: state_d = ST_MSG_REQ;
      ST_MSG_WAIT: begin
        avail_d = avail_q - 8'd1;
        if (idx_q == 2'd0) begin
          if (rdata == MSG_ID) begin
            idx_d = 2'd1;
          end else begin
            hunt      = 1'b1;
            hdr_err_d = sat_inc8(hdr_err_q);
          end
        end else if (idx_q == 2'd1) begin
          shr_d = rdata[10:0];
          idx_d = 2'd2;
        end else if (idx_q == 2'd2) begin
          shy_d = rdata[10:0];
          idx_d = 2'd3;
        end else begin
          // Outputs only move on a complete message.
          r_mid_d     = shr_q;
          y_mid_d     = shy_q;
          b_mid_d     = rdata[10:0];
          mid_valid_d = 1'b1;
          msg_cnt_d   = msg_cnt_q + 16'd1;
          idx_d       = 2'd0;
        end

        // Mid-message words are guaranteed present, so no status re-read.
        if (idx_d != 2'd0) begin
          state_d = ST_GAP;
        end else if (enable && (avail_d >= MSG_WORDS_B || (hunt && avail_d != 8'd0))) begin
          state_d = ST_GAP;
        end else if (enable) begin
          state_d = ST_STAT_REQ;
        end else begin
          cnt_d   = POLL_LOAD;
          state_d = ST_POLL_WAIT;
        end
      end
      default: state_d = ST_ID_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ID_REQ;
      cs_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      avail_q     <= '0;
      idx_q       <= '0;
      shr_q       <= '0;
      shy_q       <= '0;
      r_mid_q     <= '0;
      y_mid_q     <= '0;
      b_mid_q     <= '0;
      mid_valid_q <= 1'b0;
      id_error_q  <= 1'b0;
      hdr_err_q   <= '0;
      msg_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      avail_q     <= avail_d;
      idx_q       <= idx_d;
      shr_q       <= shr_d;
      shy_q       <= shy_d;
      r_mid_q     <= r_mid_d;
      y_mid_q     <= y_mid_d;
      b_mid_q     <= b_mid_d;
      mid_valid_q <= mid_valid_d;
      id_error_q  <= id_error_d;
      hdr_err_q   <= hdr_err_d;
      msg_cnt_q   <= msg_cnt_d;
    end
  end

  assign bus.m_chipselect = cs_q;
  assign bus.m_read       = rd_q;
  assign bus.m_write      = wr_q;
  assign bus.m_address    = addr_q;
  assign bus.m_writedata  = wdata_q;

  assign r_mid         = r_mid_q;
  assign y_mid         = y_mid_q;
  assign b_mid         = b_mid_q;
  assign mid_valid     = mid_valid_q;
  assign id_error      = id_error_q;
  assign hdr_err_count = hdr_err_q;
  assign msg_count     = msg_cnt_q;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Testbench for imgproc_msg_reader: a behavioural Avalon slave with a message
// FIFO, a stall injector and a mid_valid scoreboard monitor.
module tb_imgproc_msg_reader;
  import imgproc_pkg::*;

  localparam int P = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] r_mid, y_mid, b_mid;
  logic        mid_valid, id_error;
  logic [7:0]  hdr_err_count;
  logic [15:0] msg_count;

  imgproc_msg_reader_if bus();

  imgproc_msg_reader #(.POLL_INTERVAL(P)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .bus           (bus),
    .r_mid         (r_mid),
    .y_mid         (y_mid),
    .b_mid         (b_mid),
    .mid_valid     (mid_valid),
    .id_error      (id_error),
    .hdr_err_count (hdr_err_count),
    .msg_count     (msg_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] id_val = 32'h0;
  logic [31:0] fifo[$];
  int          stall_left = 0, bus_viol = 0, underflow = 0, cyc = 0;
  int          acc_addr[$];
  int          stat_cyc[$];
  int          msg_accepts = 0, msg_rises = 0, n_reads = 0, n_writes = 0;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;
  logic        prev_read = 1'b0, prev_stalled = 1'b0;
  logic [2:0]  prev_addr = 3'd0;
  logic [7:0]  lvl;

  initial begin
    bus.m_readdata    = 32'h0;
    bus.m_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      // a stalled request must be held unchanged into the next cycle
      if (prev_stalled && !(bus.m_chipselect && bus.m_read && bus.m_address == prev_addr))
        bus_viol++;
      if (bus.m_chipselect && bus.m_read && bus.m_address == REG_READ_MSG && stall_left > 0) begin
        bus.m_waitrequest = 1'b1;
        stall_left--;
      end else begin
        bus.m_waitrequest = 1'b0;
      end
      prev_stalled = bus.m_chipselect && bus.m_waitrequest;
      prev_addr    = bus.m_address;
      if (bus.m_read && !prev_read && bus.m_address == REG_READ_MSG) msg_rises++;
      prev_read = bus.m_read;
      if (bus.m_chipselect && !bus.m_waitrequest) begin
        if (bus.m_read) begin
          n_reads++;
          acc_addr.push_back(int'(bus.m_address));
          case (bus.m_address)
            REG_READ_ID: bus.m_readdata = id_val;
            REG_STATUS: begin
              lvl = 8'(fifo.size());
              bus.m_readdata = {16'h0, lvl, 8'h0};
              stat_cyc.push_back(cyc);
            end
            REG_READ_MSG: begin
              msg_accepts++;
              if (fifo.size() == 0) begin
                underflow++;
                bus.m_readdata = 32'h0;
              end else begin
                bus.m_readdata = fifo.pop_front();
              end
            end
            default: bus.m_readdata = 32'h0;
          endcase
        end
        if (bus.m_write) begin
          n_writes++;
          last_wr_addr = 32'(bus.m_address);
          last_wr_data = bus.m_writedata;
          if (bus.m_address == REG_STATUS && bus.m_writedata[FLUSH_BIT]) fifo.delete();
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic [10:0] r;
    logic [10:0] y;
    logic [10:0] b;
  } mids_t;

  mids_t exp_q[$];
  mids_t mon_e;
  int    exp_msgs = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && mid_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mid_valid_unexpected: pulse with r/y/b %0d/%0d/%0d and no message pending",
                   r_mid, y_mid, b_mid);
        end else begin
          mon_e = exp_q.pop_front();
          exp_msgs++;
          check("sb_r_mid", 32'(r_mid), 32'(mon_e.r));
          check("sb_y_mid", 32'(y_mid), 32'(mon_e.y));
          check("sb_b_mid", 32'(b_mid), 32'(mon_e.b));
          check("sb_msg_count", 32'(msg_count), 32'(exp_msgs));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_msgs(input int n, input int budget, input string name);
    int i = 0;
    while (int'(msg_count) < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(msg_count), 32'(n));
  endtask

  task automatic clear_logs();
    acc_addr.delete();
    stat_cyc.delete();
    n_reads     = 0;
    n_writes    = 0;
    msg_accepts = 0;
    msg_rises   = 0;
    exp_msgs    = 0;
  endtask

  int s0, m0, n, d;

  initial begin
    id_val  = 32'hDEADBEEF;
    enable  = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r_mid", 32'(r_mid), 32'd0);
    check("rst_y_mid", 32'(y_mid), 32'd0);
    check("rst_b_mid", 32'(b_mid), 32'd0);
    check("rst_mid_valid", 32'(mid_valid), 32'd0);
    check("rst_id_error", 32'(id_error), 32'd0);
    check("rst_hdr_err", 32'(hdr_err_count), 32'd0);
    check("rst_msg_count", 32'(msg_count), 32'd0);
    check("rst_bus_idle", 32'({bus.m_chipselect, bus.m_read, bus.m_write}), 32'd0);
    reset_n = 1'b1;

    // wrong block ID: fault, bus silent from then on
    for (int i = 0; i < 50 && !id_error; i++) @(negedge clk);
    check("t1_id_error", 32'(id_error), 32'd1);
    repeat (60) @(negedge clk);
    check("t1_reads", 32'(n_reads), 32'd1);
    check("t1_writes", 32'(n_writes), 32'd0);
    check("t1_first_addr", (acc_addr.size() > 0) ? 32'(acc_addr[0]) : 32'hFFFF_FFFF, 32'(REG_READ_ID));

    #2 reset_n = 1'b0;
    @(negedge clk);
    id_val = BLOCK_ID;
    clear_logs();
    check("rst2_id_error_cleared", 32'(id_error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 40 && n_writes == 0; i++) @(negedge clk);
    check("flush_writes", 32'(n_writes), 32'd1);
    check("flush_addr", last_wr_addr, 32'(REG_STATUS));
    check("flush_data", last_wr_data, 32'h10);

    // clean message
    repeat (5) @(negedge clk);
    fifo.push_back(32'h0052_4242); fifo.push_back(32'd100);
    fifo.push_back(32'd200);       fifo.push_back(32'd300);
    exp_q.push_back({11'd100, 11'd200, 11'd300});
    wait_msgs(1, 300, "t2_msg_count");

    // two junk words before the header
    repeat (3) @(negedge clk);
    fifo.push_back(32'd5);  fifo.push_back(32'd7);  fifo.push_back(32'h0052_4242);
    fifo.push_back(32'd10); fifo.push_back(32'd20); fifo.push_back(32'd30);
    exp_q.push_back({11'd10, 11'd20, 11'd30});
    wait_msgs(2, 300, "t3_msg_count");
    check("t3_hdr_err", 32'(hdr_err_count), 32'd2);

    // fewer than 4 words: keep polling, never read the FIFO
    s0 = stat_cyc.size();
    m0 = msg_accepts;
    fifo.push_back(32'h0052_4242); fifo.push_back(32'd40); fifo.push_back(32'd50);
    for (int i = 0; i < 200 && stat_cyc.size() < s0 + 3; i++) @(negedge clk);
    check("t4_status_polls", 32'(stat_cyc.size() >= s0 + 3), 32'd1);
    check("t4_no_msg_reads", 32'(msg_accepts - m0), 32'd0);
    n = stat_cyc.size();
    d = (n >= 2) ? stat_cyc[n-1] - stat_cyc[n-2] : 0;
    // poll interval plus the request/response cycles around it
    check("t4_poll_gap_in_range", 32'(d >= P && d <= P + 4), 32'd1);

    // completing word arrives; its message read stalls 3 cycles
    stall_left = 3;
    fifo.push_back(32'd60);
    exp_q.push_back({11'd40, 11'd50, 11'd60});
    wait_msgs(3, 300, "t5_msg_count");
    check("t5_stall_consumed", 32'(stall_left), 32'd0);
    check("t5_request_held", 32'(bus_viol), 32'd0);
    check("t5_one_rise_per_pop", 32'(msg_rises), 32'(msg_accepts));
    check("t5_total_pops", 32'(msg_accepts), 32'd14);
    check("t5_fifo_empty", 32'(fifo.size()), 32'd0);

    // reset in the middle of a message
    m0 = msg_accepts;
    fifo.push_back(32'h0052_4242); fifo.push_back(32'd111);
    fifo.push_back(32'd222);       fifo.push_back(32'd333);
    for (int i = 0; i < 200 && msg_accepts < m0 + 3; i++) @(negedge clk);
    check("t6_reached_word2", 32'(msg_accepts - m0), 32'd3);
    repeat (2) @(negedge clk);
    check("t6_partial_r_holds", 32'(r_mid), 32'd40);
    check("t6_partial_y_holds", 32'(y_mid), 32'd50);
    #3 reset_n = 1'b0;
    #1;
    check("t6_async_r_mid", 32'(r_mid), 32'd0);
    check("t6_async_y_mid", 32'(y_mid), 32'd0);
    check("t6_async_b_mid", 32'(b_mid), 32'd0);
    check("t6_async_msg_count", 32'(msg_count), 32'd0);
    check("t6_async_bus_drop", 32'({bus.m_chipselect, bus.m_read}), 32'd0);
    repeat (3) @(negedge clk);
    clear_logs();
    reset_n = 1'b1;
    for (int i = 0; i < 20 && acc_addr.size() == 0; i++) @(negedge clk);
    check("t6_first_access_id", (acc_addr.size() > 0) ? 32'(acc_addr[0]) : 32'hFFFF_FFFF, 32'(REG_READ_ID));
    repeat (3 * P) @(negedge clk);
    check("t6_id_ok", 32'(id_error), 32'd0);
    check("t6_fifo_flushed", 32'(fifo.size()), 32'd0);
    check("t6_outputs_stay_zero", 32'(b_mid), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("no_underflow", 32'(underflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
